// File: rtl/bomb_manager.sv
// Bomb slot manager for a tile arena: accepts placements, runs per-slot fuse and
// blast timers on a divided game tick, and publishes registered bomb/blast maps.
module bomb_manager #(
    parameter int HTILES        = 10,
    parameter int VTILES        = 6,
    parameter int SLOTS         = 4,
    parameter int MAX_PER_OWNER = 2,
    parameter int TICK_DIV      = 50_000_000,
    parameter int FUSE_TICKS    = 3,
    parameter int BLAST_TICKS   = 1,
    parameter int BLAST_R       = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     place_req,
    input  logic                     place_owner,
    input  logic [3:0]               place_h,
    input  logic [3:0]               place_v,
    input  logic [HTILES*VTILES-1:0] walkAble,
    input  logic [3:0]               a_h,
    input  logic [3:0]               a_v,
    input  logic [3:0]               b_h,
    input  logic [3:0]               b_v,
    output logic                     place_ack,
    output logic                     place_nack,
    output logic [HTILES*VTILES-1:0] bomb_map,
    output logic [HTILES*VTILES-1:0] blast_map,
    output logic [3:0]               a_cnt,
    output logic [3:0]               b_cnt,
    output logic                     hit_a,
    output logic                     hit_b,
    output logic                     explode
);

    localparam int NCELL = HTILES * VTILES;
    localparam int CW    = (NCELL > 1) ? $clog2(NCELL) : 1;
    localparam int TDW   = $clog2(TICK_DIV);
    localparam int TMAX  = (FUSE_TICKS > BLAST_TICKS) ? FUSE_TICKS : BLAST_TICKS;
    localparam int TW    = $clog2(TMAX + 1);
    localparam int SW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int DH [4] = '{1, -1, 0, 0};
    localparam int DV [4] = '{0, 0, 1, -1};

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_BLAST} slot_state_e;

    typedef struct packed {
        slot_state_e   state;
        logic [TW-1:0] tmr;
        logic [3:0]    h;
        logic [3:0]    v;
        logic          owner;
    } slot_t;

    function automatic logic on_grid(input int h, input int v);
        return (h >= 0) && (h < HTILES) && (v >= 0) && (v < VTILES);
    endfunction

    function automatic logic [CW-1:0] cell_of(input int h, input int v);
        return CW'(v * HTILES + h);
    endfunction

    slot_t            slot_q [SLOTS];
    slot_t            slot_d [SLOTS];
    logic [TDW-1:0]   tick_cnt_q, tick_cnt_d;
    logic             tick;
    logic             place_ack_q, place_nack_q, hit_a_q, hit_b_q, explode_q;
    logic [NCELL-1:0] bomb_map_q, blast_map_q;
    logic [3:0]       a_cnt_q, b_cnt_q;

    logic [NCELL-1:0] live_bomb, live_blast;
    logic [3:0]       live_a, live_b, owner_cnt;
    logic             hit_a_d, hit_b_d, req_on_grid, free_found, accept, enter_blast;
    logic [CW-1:0]    req_cell;
    logic [SW-1:0]    free_slot;

    assign tick       = (tick_cnt_q == TDW'(TICK_DIV - 1));
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + TDW'(1);

    // Maps and counts derived from the current (pre-edge) slot state.
    always_comb begin
        int  hh;
        int  vv;
        logic open;
        hh         = 0;
        vv         = 0;
        open       = 1'b0;
        live_bomb  = '0;
        live_blast = '0;
        live_a     = '0;
        live_b     = '0;
        for (int s = 0; s < SLOTS; s++) begin
            if (slot_q[s].state != S_IDLE) begin
                if (slot_q[s].owner) live_b = live_b + 4'd1;
                else                 live_a = live_a + 4'd1;
            end
            if (slot_q[s].state == S_ARMED)
                live_bomb[cell_of(int'(slot_q[s].h), int'(slot_q[s].v))] = 1'b1;
            if (slot_q[s].state == S_BLAST) begin
                live_blast[cell_of(int'(slot_q[s].h), int'(slot_q[s].v))] = 1'b1;
                // Each arm stops at the grid edge or just before the first wall.
                for (int dir = 0; dir < 4; dir++) begin
                    open = 1'b1;
                    for (int d = 1; d <= BLAST_R; d++) begin
                        hh = int'(slot_q[s].h) + DH[dir] * d;
                        vv = int'(slot_q[s].v) + DV[dir] * d;
                        if (open && on_grid(hh, vv)) begin
                            if (walkAble[cell_of(hh, vv)]) live_blast[cell_of(hh, vv)] = 1'b1;
                            else                           open = 1'b0;
                        end else begin
                            open = 1'b0;
                        end
                    end
                end
            end
        end
        hit_a_d = on_grid(int'(a_h), int'(a_v)) && live_blast[cell_of(int'(a_h), int'(a_v))];
        hit_b_d = on_grid(int'(b_h), int'(b_v)) && live_blast[cell_of(int'(b_h), int'(b_v))];
    end

    always_comb begin
        req_on_grid = on_grid(int'(place_h), int'(place_v));
        req_cell    = cell_of(int'(place_h), int'(place_v));
        owner_cnt   = place_owner ? live_b : live_a;
        free_found  = 1'b0;
        free_slot   = '0;
        for (int s = SLOTS - 1; s >= 0; s--) begin
            if (slot_q[s].state == S_IDLE) begin
                free_found = 1'b1;
                free_slot  = SW'(s);
            end
        end
        accept = place_req && req_on_grid && free_found && walkAble[req_cell] &&
                 !live_bomb[req_cell] && !live_blast[req_cell] &&
                 (int'(owner_cnt) < MAX_PER_OWNER);
    end

    always_comb begin
        enter_blast = 1'b0;
        for (int s = 0; s < SLOTS; s++) begin
            slot_d[s] = slot_q[s];
            case (slot_q[s].state)
                S_IDLE: begin
                    if (accept && (free_slot == SW'(s))) begin
                        slot_d[s].state = S_ARMED;
                        slot_d[s].tmr   = TW'(FUSE_TICKS);
                        slot_d[s].h     = place_h;
                        slot_d[s].v     = place_v;
                        slot_d[s].owner = place_owner;
                    end
                end
                S_ARMED: begin
                    // A neighbouring blast detonates this bomb regardless of the tick.
                    if (blast_map_q[cell_of(int'(slot_q[s].h), int'(slot_q[s].v))] ||
                        (tick && (slot_q[s].tmr == TW'(1)))) begin
                        slot_d[s].state = S_BLAST;
                        slot_d[s].tmr   = TW'(BLAST_TICKS);
                        enter_blast     = 1'b1;
                    end else if (tick) begin
                        slot_d[s].tmr = slot_q[s].tmr - TW'(1);
                    end
                end
                S_BLAST: begin
                    if (tick) begin
                        if (slot_q[s].tmr == TW'(1)) slot_d[s].state = S_IDLE;
                        slot_d[s].tmr = slot_q[s].tmr - TW'(1);
                    end
                end
                default: slot_d[s].state = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every slot and map
    // register updates from the same pre-edge snapshot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt_q   <= '0;
            place_ack_q  <= 1'b0;
            place_nack_q <= 1'b0;
            bomb_map_q   <= '0;
            blast_map_q  <= '0;
            a_cnt_q      <= '0;
            b_cnt_q      <= '0;
            hit_a_q      <= 1'b0;
            hit_b_q      <= 1'b0;
            explode_q    <= 1'b0;
            for (int s = 0; s < SLOTS; s++) slot_q[s] <= '0;
        end else begin
            tick_cnt_q   <= tick_cnt_d;
            place_ack_q  <= accept;
            place_nack_q <= place_req & ~accept;
            bomb_map_q   <= live_bomb;
            blast_map_q  <= live_blast;
            a_cnt_q      <= live_a;
            b_cnt_q      <= live_b;
            hit_a_q      <= hit_a_d;
            hit_b_q      <= hit_b_d;
            explode_q    <= enter_blast;
            for (int s = 0; s < SLOTS; s++) slot_q[s] <= slot_d[s];
        end
    end

    assign place_ack  = place_ack_q;
    assign place_nack = place_nack_q;
    assign bomb_map   = bomb_map_q;
    assign blast_map  = blast_map_q;
    assign a_cnt      = a_cnt_q;
    assign b_cnt      = b_cnt_q;
    assign hit_a      = hit_a_q;
    assign hit_b      = hit_b_q;
    assign explode    = explode_q;

endmodule

// File: doc/bomb_manager.md
BOMB_MANAGER -- requirements
Module: bomb_manager

Interface
REQ-001 Parameter HTILES, 10, grid columns; cell index = v*HTILES + h.
REQ-002 Parameter VTILES, 6, grid rows.
REQ-003 Parameter SLOTS, 4, concurrent bomb slots (1..8).
REQ-004 Parameter MAX_PER_OWNER, 2, live-bomb limit per player (1..SLOTS).
REQ-005 Parameter TICK_DIV, 50_000_000, clk cycles per game tick (>=2).
REQ-006 Parameter FUSE_TICKS, 3, ticks from placement to explosion (>=1).
REQ-007 Parameter BLAST_TICKS, 1, ticks a blast stays active (>=1).
REQ-008 Parameter BLAST_R, 2, blast arm length in cells (>=0).
REQ-009 clk  in  1  system clock; all state changes on its rising edge.
REQ-010 rst  in  1  asynchronous, active-low reset.
REQ-011 place_req  in  1  single-cycle placement request.
REQ-012 place_owner  in  1  requester: 0 = player A, 1 = player B.
REQ-013 place_h / place_v  in  4 / 4  requested cell column / row.
REQ-014 walkAble  in  HTILES*VTILES  1 = walkable cell, 0 = wall.
REQ-015 a_h, a_v, b_h, b_v  in  4 each  current player A/B positions.
REQ-016 place_ack / place_nack  out  1 / 1  one-cycle accept / reject result.
REQ-017 bomb_map  out  HTILES*VTILES  1 = cell holds an armed bomb.
REQ-018 blast_map  out  HTILES*VTILES  1 = cell currently in a blast.
REQ-019 a_cnt, b_cnt  out  4 each  live (armed or blasting) bombs per owner.
REQ-020 hit_a, hit_b  out  1 each  player position lies in blast_map.
REQ-021 explode  out  1  one-cycle pulse when any slot enters BLAST.

Function
REQ-022 Tick: free-running counter 0..TICK_DIV-1; internal tick pulse for one cycle when the counter wraps to 0.
REQ-023 Slot FSM per slot: IDLE -> ARMED (on accepted placement) -> BLAST (fuse reaches 0, or chain) -> IDLE (blast counter reaches 0).
REQ-024 ARMED: fuse loads FUSE_TICKS on accept and decrements per tick; entering BLAST on the tick where fuse goes 1 -> 0.
REQ-025 BLAST: counter loads BLAST_TICKS on entry and decrements per tick; IDLE on the tick where it goes 1 -> 0.
REQ-026 Chain: an ARMED slot whose cell is set in registered blast_map enters BLAST on the next clk edge regardless of tick.
REQ-027 Accept iff: h<HTILES, v<VTILES, walkAble[cell]=1, bomb_map[cell]=0, no BLAST on cell, owner count < MAX_PER_OWNER, a slot is IDLE.
REQ-028 Accepted request takes the lowest-index IDLE slot; otherwise nack; ack/nack asserted the cycle after place_req, exactly one of them.
REQ-029 A slot freed and a request arriving in the same cycle: request sees the pre-edge state (freed slot usable next cycle only).
REQ-030 Blast pattern: centre cell plus up to BLAST_R cells in each of 4 directions, clipped at grid edges; each arm stops before the first wall (wall not marked).
REQ-031 bomb_map, blast_map, a_cnt, b_cnt, hit_a, hit_b are registered: they reflect slot state with 1-cycle latency.
REQ-032 explode pulses once per cycle in which one or more slots transition to BLAST.
REQ-033 Overlapping blasts OR together; hit_a/hit_b use the same registered blast_map (out-of-range positions never hit).

Reset
REQ-034 rst low asynchronously forces all slots IDLE, tick counter 0, and every output to 0.
REQ-035 Reset mid-fuse or mid-blast discards the bomb; after release, first tick occurs TICK_DIV cycles later.

Verification (HTILES=10, VTILES=6, SLOTS=2, MAX_PER_OWNER=1, TICK_DIV=4, FUSE_TICKS=3, BLAST_TICKS=2, BLAST_R=1, all walkable unless stated)
REQ-036 A places at (4,2) -> ack next cycle, bomb_map bit 24 set, a_cnt=1; after 3 ticks explode pulses, blast_map bits {14,23,24,25,34} set for 2 ticks, then all clear, a_cnt=0.
REQ-037 A places (0,0) then A places (5,5) while first is live -> second gets nack, a_cnt stays 1; B places (5,5) -> ack, b_cnt=1.
REQ-038 Wall at (3,2), A bomb at (2,2) with a_h=2,a_v=2 -> blast bits {12,21,22,32} only (bit 23 clear), hit_a=1.
REQ-039 A at (4,2), B at (5,2) placed 1 tick later -> A explodes, B enters BLAST the following cycle (chain), second explode pulse.
REQ-040 Both slots busy, third request -> nack; request onto a wall or h=12 -> nack; request on bomb cell -> nack.
REQ-041 rst pulsed low mid-fuse -> bomb_map, blast_map, counts, ack/nack all 0 immediately; no explode after release.
